paddle_ctrl: RTL and testbench
==============================

Name: paddle_ctrl

Overview:
- Parametrised successor to the one-hot shift-register paddle. Holds the paddle position as a binary row index and derives the lit-row mask from it.
- Rate-limits movement against a game tick, with a per-direction movement state machine and clamping at the field edges.
- Sits between the player input synchroniser and the renderer/collision logic; one instance per player.

Parameters:
- FIELD_H, 32, field height in rows; bit FIELD_H-1 is the top row.
- PAD_LEN, 8, paddle length in rows (1 <= PAD_LEN <= FIELD_H).
- MOVE_DIV, 4, ticks per step while a direction is held (>= 1).
- RESET_POS, (FIELD_H-PAD_LEN)/2, position loaded on reset (must be <= FIELD_H-PAD_LEN).
- POS_W, $clog2(FIELD_H-PAD_LEN+1) (min 1), position width; derived, not overridden.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous reset, active-high.
- tick, input, 1, single-cycle game-step strobe; all movement is qualified by it.
- moveUp, input, 1, level; request movement toward row FIELD_H-1.
- moveDown, input, 1, level; request movement toward row 0.
- verticalPosition, output, POS_W, row index of the paddle's lowest lit row.
- paddleMask, output, FIELD_H, bits [verticalPosition+PAD_LEN-1 : verticalPosition] set, all others clear.
- atTop, output, 1, verticalPosition == FIELD_H-PAD_LEN.
- atBottom, output, 1, verticalPosition == 0.

Behaviour:
- Reset (sampled on the rising clk edge while reset=1):
  - verticalPosition=RESET_POS, state=IDLE, divider count=0.
  - paddleMask, atTop and atBottom follow from the position. For defaults: position 12, mask 32'h000FF000, atTop=0, atBottom=0.
  - Reset overrides tick and all inputs in the same cycle.
- Outputs are registered position plus combinational decode. paddleMask/atTop/atBottom change in the same cycle as verticalPosition.
- Request decode, evaluated each cycle:
  - UP = moveUp & ~moveDown.
  - DN = moveDown & ~moveUp.
  - NONE = otherwise; both pressed is NONE.
- States: IDLE, MOVE_UP, MOVE_DN.
  - IDLE: on tick with UP go to MOVE_UP; with DN go to MOVE_DN. In both cases take one step on that same tick (first step is immediate) and set count=MOVE_DIV-1.
  - MOVE_UP / MOVE_DN, request unchanged: on tick, if count==0 take a step and reload count=MOVE_DIV-1, else decrement count.
  - MOVE_UP / MOVE_DN, request becomes NONE: return to IDLE on the next clk edge, regardless of tick; count=0, no step.
  - MOVE_UP / MOVE_DN, request reverses: on tick, switch to the opposite state and take an immediate step there (same rule as leaving IDLE). Without tick, hold state and count.
- Step rules:
  - An up step adds 1 to the position; a down step subtracts 1.
  - Clamp at the edges: an up step at atTop and a down step at atBottom leave the position unchanged. The FSM stays in its move state and the count still reloads.
  - No wrap-around ever.
- Without tick the position never changes. The only exceptions are reset and the NONE->IDLE return, which does not move the paddle.
- MOVE_DIV=1: a step occurs on every tick while held.
- PAD_LEN=FIELD_H: position is pinned at 0 and atTop=atBottom=1.
- Latency: a step commits on the clk edge where tick=1. The new position is visible the following cycle.

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- Defined:
  - A saturating 3-bit run counter counts consecutive steps in the current move state.
  - Once it reaches 4, the reload value becomes (MOVE_DIV-1)>>1, which roughly doubles the speed.
  - The run counter clears on IDLE, on reversal, on reset and on any clamped step.
- Not defined: the run counter is absent and the reload is always MOVE_DIV-1.

Test Plan:
- Reset with defaults -> verticalPosition=12, paddleMask=32'h000FF000, atTop=0, atBottom=0. A tick pulse with no input keeps those values.
- moveUp held, tick every cycle, MOVE_DIV=4 -> position 13 after the first tick. Then 14, 15 after ticks 5 and 9; no change on the other ticks.
- moveUp held from position 23 -> atTop=1 and mask=32'hFF000000. Further ticks hold at 24 (FIELD_H-PAD_LEN), no wrap.
- moveUp and moveDown both held for 20 ticks from position 12 -> position stays 12, FSM in IDLE.
- In MOVE_UP at 15, switch to moveDown and pulse tick -> position 14 on that tick. Reset asserted mid-move -> position 12 and IDLE on the next edge, even with tick=1.
- PADDLE_ACCEL_EN defined, MOVE_DIV=4, moveDown held from 12 -> steps on ticks 1,5,9,13. After the 4th step the interval becomes 2 ticks: position 7 on tick 15.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: rate-limited paddle position with edge clamping and a decoded lit-row mask.
// Optional macro PADDLE_ACCEL_EN halves the step interval after four consecutive steps.
module paddle_ctrl #(
   parameter int FIELD_H   = 32,
   parameter int PAD_LEN   = 8,
   parameter int MOVE_DIV  = 4,
   parameter int RESET_POS = (FIELD_H - PAD_LEN) / 2,
   localparam int POS_W    = (FIELD_H - PAD_LEN > 0) ? $clog2(FIELD_H - PAD_LEN + 1) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               moveUp,
   input  logic               moveDown,
   output logic [POS_W-1:0]   verticalPosition,
   output logic [FIELD_H-1:0] paddleMask,
   output logic               atTop,
   output logic               atBottom
);

   localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [POS_W-1:0] MAX_POS     = POS_W'(FIELD_H - PAD_LEN);
   localparam logic [CNT_W-1:0] SLOW_RELOAD = CNT_W'(MOVE_DIV - 1);
`ifdef PADDLE_ACCEL_EN
   localparam logic [CNT_W-1:0] FAST_RELOAD = CNT_W'((MOVE_DIV - 1) >> 1);
`endif

   typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDn} state_e;

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] reload;
   logic             req_up, req_dn;
   logic             at_top, at_bot;
   logic             step, step_up, restart, clamped;
`ifdef PADDLE_ACCEL_EN
   logic [2:0]       run_q, run_d;
`endif

   assign req_up = moveUp & ~moveDown;
   assign req_dn = moveDown & ~moveUp;
   assign at_top = (pos_q == MAX_POS);
   assign at_bot = (pos_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      step    = 1'b0;
      step_up = 1'b0;
      restart = 1'b0;
      clamped = 1'b0;
      case (state_q)
         StIdle: begin
            if (tick && (req_up || req_dn)) begin
               state_d = req_up ? StMoveUp : StMoveDn;
               step    = 1'b1;
               step_up = req_up;
               restart = 1'b1;
            end
         end
         StMoveUp, StMoveDn: begin
            if (!req_up && !req_dn) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (tick) begin
               step_up = req_up;
               if ((state_q == StMoveUp) == req_up) begin
                  if (cnt_q == '0) step = 1'b1;
                  else             cnt_d = cnt_q - 1'b1;
               end else begin
                  // Reversal behaves like leaving idle: immediate step in the new direction.
                  state_d = req_up ? StMoveUp : StMoveDn;
                  step    = 1'b1;
                  restart = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      clamped = step & (step_up ? at_top : at_bot);
      if (step && !clamped) pos_d = step_up ? pos_q + 1'b1 : pos_q - 1'b1;

`ifdef PADDLE_ACCEL_EN
      run_d = run_q;
      if (state_d == StIdle || restart || clamped) run_d = '0;
      if (step && !clamped && run_d != 3'd7) run_d = run_d + 1'b1;
      reload = (run_d >= 3'd4) ? FAST_RELOAD : SLOW_RELOAD;
`else
      reload = SLOW_RELOAD;
`endif
      if (step) cnt_d = reload;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pos_q   <= POS_W'(RESET_POS);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PADDLE_ACCEL_EN
   always_ff @(posedge clk) begin
      if (reset) run_q <= '0;
      else       run_q <= run_d;
   end
`endif

   always_comb begin
      paddleMask = '0;
      for (int i = 0; i < FIELD_H; i++) begin
         paddleMask[i] = (i >= int'(pos_q)) && (i < int'(pos_q) + PAD_LEN);
      end
   end

   assign verticalPosition = pos_q;
   assign atTop            = at_top;
   assign atBottom         = at_bot;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: vector table plus multi-cycle sequences, checked through a scoreboard queue.
module tb_paddle_ctrl;

   logic        clk = 1'b0;
   logic        reset, tick, moveUp, moveDown;
   logic [4:0]  verticalPosition;
   logic [31:0] paddleMask;
   logic        atTop, atBottom;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {string tag; int pos;} exp_t;
   typedef struct {string tag; logic r; logic t; logic u; logic d; int pos;} vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   paddle_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .tick             (tick),
      .moveUp           (moveUp),
      .moveDown         (moveDown),
      .verticalPosition (verticalPosition),
      .paddleMask       (paddleMask),
      .atTop            (atTop),
      .atBottom         (atBottom)
   );

   always #5 clk = ~clk;

   function automatic void add_vec(string tag, logic r, logic t, logic u, logic d, int pos);
      vec_t v;
      v.tag = tag; v.r = r; v.t = t; v.u = u; v.d = d; v.pos = pos;
      vecs.push_back(v);
   endfunction

   task automatic check(string tag, int pos);
      logic [31:0] m;
      logic        top, bot;
      m   = 32'h0000_00FF << pos;
      top = (pos == 24);
      bot = (pos == 0);
      n_cmp++;
      if ($isunknown(verticalPosition) || int'(verticalPosition) != pos) begin
         n_bad++;
         $display("FAIL %s pos: got %0d want %0d", tag, verticalPosition, pos);
      end
      n_cmp++;
      if (paddleMask !== m) begin
         n_bad++;
         $display("FAIL %s mask: got %h want %h", tag, paddleMask, m);
      end
      n_cmp++;
      if (atTop !== top) begin
         n_bad++;
         $display("FAIL %s atTop: got %b want %b", tag, atTop, top);
      end
      n_cmp++;
      if (atBottom !== bot) begin
         n_bad++;
         $display("FAIL %s atBottom: got %b want %b", tag, atBottom, bot);
      end
   endtask

   // Drive one cycle of inputs, queue the position expected after the edge, then compare.
   task automatic drive(string tag, logic r, logic t, logic u, logic d, int pos);
      exp_t e;
      reset = r; tick = t; moveUp = u; moveDown = d;
      e.tag = tag; e.pos = pos;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e.tag, e.pos);
   endtask

   int exp_pos;
`ifdef PADDLE_ACCEL_EN
   int accel_exp[16] = '{11, 11, 11, 11, 10, 10, 10, 10, 9, 9, 9, 9, 8, 8, 7, 7};
`endif

   initial begin
      reset = 1'b1; tick = 1'b0; moveUp = 1'b0; moveDown = 1'b0;

      add_vec("reset",        1, 0, 0, 0, 12);
      add_vec("tick_idle",    0, 1, 0, 0, 12);
      add_vec("up_t1",        0, 1, 1, 0, 13);
      add_vec("up_t2",        0, 1, 1, 0, 13);
      add_vec("up_t3",        0, 1, 1, 0, 13);
      add_vec("up_t4",        0, 1, 1, 0, 13);
      add_vec("up_t5",        0, 1, 1, 0, 14);
      add_vec("up_t6",        0, 1, 1, 0, 14);
      add_vec("up_t7",        0, 1, 1, 0, 14);
      add_vec("up_t8",        0, 1, 1, 0, 14);
      add_vec("up_t9",        0, 1, 1, 0, 15);
      add_vec("rev_no_tick",  0, 0, 0, 1, 15);
      add_vec("reverse",      0, 1, 0, 1, 14);
      add_vec("reset_mid",    1, 1, 0, 1, 12);
      add_vec("idle_after_r", 0, 1, 0, 1, 11);
      add_vec("reset2",       1, 0, 0, 0, 12);

      foreach (vecs[i]) drive(vecs[i].tag, vecs[i].r, vecs[i].t, vecs[i].u, vecs[i].d, vecs[i].pos);

      for (int k = 0; k < 20; k++) drive("both_held", 0, 1, 1, 1, 12);
      drive("idle_after_both", 0, 1, 1, 0, 13);

      // Held without tick never moves; releasing drops to idle so the next tick steps at once.
      for (int k = 0; k < 3; k++) drive("hold_no_tick", 0, 0, 1, 0, 13);
      drive("release", 0, 0, 0, 0, 13);
      drive("none_idle_restep", 0, 1, 1, 0, 14);

`ifndef PADDLE_ACCEL_EN
      drive("reset_top", 1, 0, 0, 0, 12);
      for (int k = 1; k <= 60; k++) begin
         exp_pos = 12 + (k + 3) / 4;
         if (exp_pos > 24) exp_pos = 24;
         drive("clamp_top", 0, 1, 1, 0, exp_pos);
      end
      drive("reset_bot", 1, 0, 0, 0, 12);
      for (int k = 1; k <= 60; k++) begin
         exp_pos = 12 - (k + 3) / 4;
         if (exp_pos < 0) exp_pos = 0;
         drive("clamp_bot", 0, 1, 0, 1, exp_pos);
      end
`endif

      drive("reset_accel", 1, 0, 0, 0, 12);
      for (int k = 1; k <= 16; k++) begin
`ifdef PADDLE_ACCEL_EN
         exp_pos = accel_exp[k-1];
`else
         exp_pos = 12 - (k + 3) / 4;
`endif
         drive("down_rate", 0, 1, 0, 1, exp_pos);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
